mv_job_sched: RTL
=================

Name: mv_job_sched

Overview:
- Hardware sequencer for the 8-core matrix-vector engine. It replaces software toggling of the matw/run/last control bits.
- After one start pulse it runs the full job:
  - a matrix load phase (optional)
  - NUM source blocks streamed in
  - NUM result blocks streamed out
- It then raises a done pulse and a sticky status.
- It sits between the AXI-Lite register file (which supplies start/config) and the engine control inputs matw/run/last. It watches the AXIS beat handshakes to know phase completion.

Parameters:
- MAT_BEATS, 1024, 64-bit input beats per matrix load (8 cores x 128 words)
- SRC_BEATS, 1024, input beats per source block (src_a space)
- DST_BEATS, 32, output beats per result block (stream_a space)
- NUMW, 16, width of block-count configuration

Ports:
- AXIS_ACLK  in  1  clock
- AXIS_ARESETN  in  1  reset
- start  in  1  one-cycle pulse, begins job when idle
- abort  in  1  one-cycle pulse, kills job
- cfg_num  in  NUMW  number of source/result blocks in job
- cfg_skip_mat  in  1  1 = reuse loaded matrix, skip MATW phase
- src_beat  in  1  S_AXIS_TVALID & S_AXIS_TREADY
- dst_beat  in  1  M_AXIS_TVALID & M_AXIS_TREADY
- matw  out  1  matrix-write enable to engine
- run  out  1  run enable to engine (low = engine datapath reset)
- last  out  1  final-block marker to engine
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- done_sticky  out  1  set at done, cleared by next start or abort
- blk_in_cnt  out  NUMW  source blocks fully received
- blk_out_cnt  out  NUMW  result blocks fully sent

Behaviour:
- Clock and reset: single clock AXIS_ACLK; reset AXIS_ARESETN is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; all counters 0.
- States: IDLE, MATW, GAP, RUN, FLUSH.
- IDLE:
  - start with cfg_num==0: done pulses next cycle, done_sticky=1, no phase entered.
  - start with cfg_skip_mat=1: go to GAP.
  - start otherwise: go to MATW.
  - cfg_num and cfg_skip_mat are latched on start; later changes are ignored.
  - start clears done_sticky, blk_in_cnt and blk_out_cnt.
- MATW:
  - matw=1; beat counter counts src_beat.
  - On the MAT_BEATS-th beat, matw drops the following cycle and the state becomes GAP.
- GAP: exactly one cycle with matw=0 and run=0 (engine pointer settle), then RUN.
- RUN:
  - run=1.
  - src_beat: beat counter wraps at SRC_BEATS; each wrap increments blk_in_cnt.
  - dst_beat: counter wraps at DST_BEATS; each wrap increments blk_out_cnt.
  - last goes to 1 the cycle after blk_in_cnt reaches num and stays 1 until leaving RUN.
  - src_beat after blk_in_cnt==num is ignored (not counted).
  - When blk_out_cnt reaches num, go to FLUSH.
- FLUSH: one cycle with run=0 and last=0; done=1 and done_sticky=1 in this same cycle; next state IDLE.
- Counter rules:
  - A src_beat and a dst_beat in the same cycle are both counted.
  - Counter widths are clog2 of the respective BEATS parameter and wrap exactly.
- busy=1 in MATW, GAP, RUN and FLUSH.
- start while busy is ignored.
- abort:
  - In any state, the next cycle is IDLE with matw=run=last=0.
  - done is not pulsed; done_sticky=0; counters hold their values for debug.
  - abort and start in the same cycle: abort wins.
- Async reset mid-job: immediate return to reset values; the engine sees run=0.

Decomposition:
- Shared package mv_pkg:
  - state enum (IDLE/MATW/GAP/RUN/FLUSH)
  - MAT_BEATS/SRC_BEATS/DST_BEATS defaults
  - NUMW
- One natural sub-module, mv_beat_cnt: a parameterised modulo-N beat counter with clear, enable, wrap pulse. It is instantiated for src beats (MAT_BEATS/SRC_BEATS selected by state) and dst beats.

Test Plan:
1. Full job, cfg_num=2, skip=0: 1024 src beats, then 2048 src beats and 64 dst beats.
   - matw high for exactly 1024 beats, then one GAP cycle.
   - last rises the cycle after the 2048th run beat.
   - done pulses once after the 64th dst beat; blk_in_cnt=blk_out_cnt=2.
2. cfg_skip_mat=1, cfg_num=1: matw never asserts; run rises 2 cycles after start; done after 32 dst beats.
3. cfg_num=0: done pulses the cycle after start; matw, run and busy never go high.
4. Abort at matrix beat 500: outputs are 0 the next cycle, no done pulse, done_sticky=0. A following start reloads the full 1024 matrix beats.
5. Simultaneous and extra beats:
   - src_beat and dst_beat high in the same cycle: both counters advance.
   - Extra src_beats after the final block do not change blk_in_cnt.
   - start while busy does not restart the job.
6. Async reset asserted mid-RUN (non-clock-aligned): all outputs are 0 immediately; state is IDLE after deassertion.

Source files
------------

// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector job sequencer: phase encoding,
// default beat counts per phase and the block-count width.
package mv_pkg;

    localparam int MAT_BEATS = 1024;  // 64-bit beats per matrix load (8 cores x 128 words)
    localparam int SRC_BEATS = 1024;  // input beats per source block
    localparam int DST_BEATS = 32;    // output beats per result block
    localparam int NUMW      = 16;    // width of the block-count configuration

    // Job phases, in the order a full job walks through them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MATW  = 3'd1,
        ST_GAP   = 3'd2,
        ST_RUN   = 3'd3,
        ST_FLUSH = 3'd4
    } state_e;

endpackage

// File: rtl/mv_beat_cnt.sv
// Modulo-N beat counter. The terminal value (N-1) is an input so one
// instance can serve phases with different beat counts. wrap pulses
// combinationally on the enabled beat that takes the count back to zero.
// clr has priority over en.
module mv_beat_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last_val,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, wrap at the terminal value, or step on enable.
    always_comb begin
        wrap  = en && (cnt_q == last_val);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mv_job_sched.sv
// Job sequencer for the 8-core matrix-vector engine. One start pulse walks
// the engine through matrix load, a one-cycle pointer-settle gap, the run
// phase (NUM source blocks in, NUM result blocks out) and a flush cycle,
// driving matw/run/last and reporting done / done_sticky.
//
// Handshake: src_beat/dst_beat are already-qualified AXIS transfers
// (TVALID & TREADY); each high cycle is exactly one beat, and there is no
// back-pressure from this block. start/abort are single-cycle pulses;
// start is only accepted in IDLE and abort always wins over start.
module mv_job_sched
    import mv_pkg::*;
#(
    parameter int P_MAT_BEATS = MAT_BEATS,
    parameter int P_SRC_BEATS = SRC_BEATS,
    parameter int P_DST_BEATS = DST_BEATS
) (
    input  logic            AXIS_ACLK,
    input  logic            AXIS_ARESETN,
    input  logic            start,
    input  logic            abort,
    input  logic [NUMW-1:0] cfg_num,
    input  logic            cfg_skip_mat,
    input  logic            src_beat,
    input  logic            dst_beat,
    output logic            matw,
    output logic            run,
    output logic            last,
    output logic            busy,
    output logic            done,
    output logic            done_sticky,
    output logic [NUMW-1:0] blk_in_cnt,
    output logic [NUMW-1:0] blk_out_cnt,
    output logic [2:0]      state_dbg
);

    // The source counter is shared by matrix load and run, so it is sized
    // for the larger of the two phases.
    localparam int SRC_MAX = (P_MAT_BEATS > P_SRC_BEATS) ? P_MAT_BEATS : P_SRC_BEATS;
    localparam int SRC_CW  = $clog2(SRC_MAX);
    localparam int DST_CW  = $clog2(P_DST_BEATS);

    state_e          state_q, state_d;
    logic [NUMW-1:0] num_q, num_d;
    logic [NUMW-1:0] blk_in_q, blk_in_d;
    logic [NUMW-1:0] blk_out_q, blk_out_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            sticky_q, sticky_d;

    logic              start_acc;
    logic              src_en, src_clr, src_wrap;
    logic              dst_en, dst_clr, dst_wrap;
    logic [SRC_CW-1:0] src_last, src_cnt;
    logic [DST_CW-1:0] dst_cnt;

    // Beat counter controls: counters only advance in the phase that owns
    // them, and restart on an accepted start and in the gap before RUN.
    always_comb begin
        start_acc = start && !abort && (state_q == ST_IDLE);
        src_en    = src_beat && !abort &&
                    ((state_q == ST_MATW) ||
                     ((state_q == ST_RUN) && (blk_in_q != num_q)));
        dst_en    = dst_beat && !abort && (state_q == ST_RUN);
        src_clr   = start_acc || (state_q == ST_GAP);
        dst_clr   = start_acc || (state_q == ST_GAP);
        src_last  = (state_q == ST_MATW) ? SRC_CW'(P_MAT_BEATS - 1)
                                         : SRC_CW'(P_SRC_BEATS - 1);
    end

    mv_beat_cnt #(.W(SRC_CW)) u_src_cnt (
        .clk      (AXIS_ACLK),
        .rst_n    (AXIS_ARESETN),
        .clr      (src_clr),
        .en       (src_en),
        .last_val (src_last),
        .cnt      (src_cnt),
        .wrap     (src_wrap)
    );

    mv_beat_cnt #(.W(DST_CW)) u_dst_cnt (
        .clk      (AXIS_ACLK),
        .rst_n    (AXIS_ARESETN),
        .clr      (dst_clr),
        .en       (dst_en),
        .last_val (DST_CW'(P_DST_BEATS - 1)),
        .cnt      (dst_cnt),
        .wrap     (dst_wrap)
    );

    // Phase sequencing, block counting and done/last generation.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        blk_in_d  = blk_in_q;
        blk_out_d = blk_out_q;
        last_d    = 1'b0;
        done_d    = 1'b0;
        sticky_d  = sticky_q;
        if (abort) begin
            // Block counts are left as-is so software can see how far it got.
            state_d  = ST_IDLE;
            sticky_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_d     = cfg_num;
                        blk_in_d  = '0;
                        blk_out_d = '0;
                        sticky_d  = 1'b0;
                        if (cfg_num == '0) begin
                            done_d   = 1'b1;
                            sticky_d = 1'b1;
                        end else if (cfg_skip_mat) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_MATW;
                        end
                    end
                end
                ST_MATW: begin
                    if (src_wrap) begin
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (src_wrap) begin
                        blk_in_d = blk_in_q + 1'b1;
                    end
                    if (dst_wrap) begin
                        blk_out_d = blk_out_q + 1'b1;
                    end
                    if (blk_out_d == num_q) begin
                        state_d  = ST_FLUSH;
                        done_d   = 1'b1;
                        sticky_d = 1'b1;
                    end else begin
                        last_d = (blk_in_d == num_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Job state registers.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            blk_in_q  <= '0;
            blk_out_q <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            blk_in_q  <= blk_in_d;
            blk_out_q <= blk_out_d;
            last_q    <= last_d;
            done_q    <= done_d;
            sticky_q  <= sticky_d;
        end
    end

    // Engine controls decode straight from the registered phase.
    always_comb begin
        matw        = (state_q == ST_MATW);
        run         = (state_q == ST_RUN);
        busy        = (state_q != ST_IDLE);
        last        = last_q;
        done        = done_q;
        done_sticky = sticky_q;
        blk_in_cnt  = blk_in_q;
        blk_out_cnt = blk_out_q;
        state_dbg   = state_q;
    end

endmodule
